banco_registri: RTL
===================

// Module: banco_registri
// PURPOSE
//   Parametrised register bank: NREG registers of W bits each, with one write port and two read ports.
//   It generalises the single write-enabled register to a multi-entry store.
//   It adds asynchronous reset, optional hardwired-zero register 0, optional write-to-read bypass,
//   and per-entry "written since reset" flags.
//   It is the register bank used by the datapath exercises (ALU operand fetch and result writeback).
// PARAMETERS
//   W       8   data width of each register, in bits (>=1)
//   NREG    8   number of registers (>=2, power of two)
//   AW      3   address width; must equal log2(NREG)
//   ZERO_R0 0   1: register 0 always reads 0, writes to it are ignored, valid_* for it reads 1
//   BYPASS  0   1: a read of the address being written this cycle returns wdata (write-through)
// PORTS
//   clock    in   1   clock; all state updates on the rising edge
//   reset    in   1   asynchronous, active-high; clears all registers and valid flags
//   we       in   1   write enable; sampled on the rising edge of clock
//   waddr    in   AW  write address
//   wdata    in   W   write data
//   raddr_a  in   AW  read address, port A
//   rdata_a  out  W   read data, port A (combinational)
//   valid_a  out  1   1 if register raddr_a has been written since the last reset
//   raddr_b  in   AW  read address, port B
//   rdata_b  out  W   read data, port B (combinational)
//   valid_b  out  1   1 if register raddr_b has been written since the last reset
// BEHAVIOUR
//   - Reset: while reset=1, all NREG registers = 0 and all valid flags = 0, independent of clock.
//     Hence rdata_a = rdata_b = 0 and valid_a = valid_b = 0, except valid for r0 when ZERO_R0 = 1.
//     Deasserting reset mid-cycle takes effect from the next rising edge; no spurious write occurs.
//   - Write: at rising edge with reset=0 and we=1, reg[waddr] <= wdata and valid[waddr] <= 1.
//     we=0 leaves all state unchanged (hold).
//   - Write latency: the new value is visible on the read ports in the same cycle, after the edge.
//   - Read: rdata_x = reg[raddr_x] and valid_x = valid[raddr_x]; purely combinational, zero latency.
//   - Both read ports may address the same register, including the one being written.
//   - BYPASS=1: if we=1, reset=0 and raddr_x == waddr before the edge, then rdata_x = wdata and valid_x = 1.
//     With ZERO_R0=1, r0 is never bypassed.
//   - BYPASS=0: before the edge, the read port shows the old contents.
//   - ZERO_R0=1: a write to r0 leaves no state change; rdata for r0 = 0 always.
//   - Address range: all addresses are in range (NREG = 2^AW); no wrap or error handling is needed.
//   - Width: wdata is stored unmodified; no sign or zero extension.
//   - X-handling: we=X or waddr=X must never be silently treated as a write in simulation;
//     the bench checks that known inputs never produce X outputs.
// TESTING
//   1 Reset: reset=1 for 3 cycles, W=8/NREG=8 -> all rdata=0, valid=0; release -> still 0 until first write.
//   2 Write/read: write 7->r2, 12->r5, 5->r7 on consecutive edges -> read r2/r5/r7 on A/B = 7/12/5, valid=1;
//     unwritten r3 -> 0, valid=0.
//   3 Hold: we=0, wdata=255, waddr=2 for 4 cycles -> r2 stays 7.
//   4 Same-cycle read of the register being written, r4 old=9 new=33:
//     BYPASS=0 -> rdata=9 before the edge, 33 after; BYPASS=1 -> 33 before the edge.
//   5 ZERO_R0=1: write 200->r0 -> rdata for r0 = 0; both ports on r1 after writing 17 -> both 17.
//   6 Async reset mid-operation: assert reset at t=edge+1 with r5=12 -> rdata_a=0 immediately, without waiting for a clock;
//     a we=1 edge during reset is ignored.

Source files
------------

// File: rtl/banco_registri_if.sv
// banco_registri_if: write and dual read bus of the register bank.
//   Master drives : we, waddr[AW], wdata[W], raddr_a[AW], raddr_b[AW]
//   Slave drives  : rdata_a[W], valid_a, rdata_b[W], valid_b
interface banco_registri_if #(
    parameter int W  = 8,
    parameter int AW = 3
);
    logic          we;
    logic [AW-1:0] waddr;
    logic [W-1:0]  wdata;
    logic [AW-1:0] raddr_a;
    logic [W-1:0]  rdata_a;
    logic          valid_a;
    logic [AW-1:0] raddr_b;
    logic [W-1:0]  rdata_b;
    logic          valid_b;

    modport master (
        output we, waddr, wdata, raddr_a, raddr_b,
        input  rdata_a, valid_a, rdata_b, valid_b
    );

    modport slave (
        input  we, waddr, wdata, raddr_a, raddr_b,
        output rdata_a, valid_a, rdata_b, valid_b
    );
endinterface

// File: rtl/banco_registri.sv
// banco_registri: NREG x W register bank, one write port, two combinational read ports.
//   clock : rising-edge clock for all state updates
//   reset : asynchronous active-high, clears registers and written flags
//   bus   : slave side of banco_registri_if (write port, read ports A/B with valid flags)
//   ZERO_R0 hardwires r0 to zero; BYPASS forwards wdata to a read of the address being written.
module banco_registri #(
    parameter int W       = 8,
    parameter int NREG    = 8,
    parameter int AW      = 3,
    parameter int ZERO_R0 = 0,
    parameter int BYPASS  = 0
) (
    input  logic              clock,
    input  logic              reset,
    banco_registri_if.slave   bus
);
    logic [W-1:0]    regs_q [NREG];
    logic [W-1:0]    regs_d [NREG];
    logic [NREG-1:0] valid_q;
    logic [NREG-1:0] valid_d;
    logic            wen;
    logic            byp_a;
    logic            byp_b;
    logic            zero_a;
    logic            zero_b;

    // an X on we evaluates false here, so it never counts as a write
    assign wen    = (bus.we == 1'b1) && !(ZERO_R0 != 0 && bus.waddr == '0);
    assign zero_a = ZERO_R0 != 0 && bus.raddr_a == '0;
    assign zero_b = ZERO_R0 != 0 && bus.raddr_b == '0;
    // wen already excludes r0 when it is hardwired, so r0 is never forwarded
    assign byp_a  = BYPASS != 0 && !reset && wen && bus.raddr_a == bus.waddr;
    assign byp_b  = BYPASS != 0 && !reset && wen && bus.raddr_b == bus.waddr;

    always_comb begin
        regs_d  = regs_q;
        valid_d = valid_q;
        if (wen) begin
            regs_d[bus.waddr]  = bus.wdata;
            valid_d[bus.waddr] = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            regs_q  <= '{default: '0};
            valid_q <= '0;
        end else begin
            regs_q  <= regs_d;
            valid_q <= valid_d;
        end
    end

    assign bus.rdata_a = zero_a ? '0 : byp_a ? bus.wdata : regs_q[bus.raddr_a];
    assign bus.rdata_b = zero_b ? '0 : byp_b ? bus.wdata : regs_q[bus.raddr_b];
    assign bus.valid_a = zero_a || byp_a || valid_q[bus.raddr_a];
    assign bus.valid_b = zero_b || byp_b || valid_q[bus.raddr_b];
endmodule
